rvfi_csr_shadow_check: RTL and testbench
========================================

Name: rvfi_csr_shadow_check

Overview:
- Sequential consumer of one RVFI retirement channel, for a single CSR.
- Keeps a shadow copy of the CSR, built from per-bit write masks of retired instructions.
- On every later read, flags any readback bit that differs from a known shadow bit.
- Also checks retirement-order continuity and a retire liveness watchdog; it complements the per-instruction CSR write check with cross-instruction history.

Parameters:
- XLEN, 32, data width of the CSR and its mask fields (32 or 64).
- ORDER_W, 64, width of rvfi_order.
- TIMEOUT, 16, max consecutive cycles without a valid retire after the first retire; 0 disables the watchdog.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- rvfi_valid  in  1  retire strobe.
- rvfi_order  in  ORDER_W  retire index.
- rvfi_trap  in  1  instruction trapped.
- csr_rmask  in  XLEN  bits read by this instruction.
- csr_wmask  in  XLEN  bits written by this instruction.
- csr_rdata  in  XLEN  value read (pre-write).
- csr_wdata  in  XLEN  value written (post-write).
- shadow  out  XLEN  current shadow value.
- known  out  XLEN  shadow bits valid.
- err_data  out  1  sticky readback mismatch.
- err_order  out  1  sticky order discontinuity.
- err_timeout  out  1  sticky watchdog expiry.
- err_any  out  1  OR of the three error flags, registered.

Behaviour:
- Reset (reset==0 at a clock edge):
  - shadow=0, known=0, all err_* =0.
  - FSM=IDLE, watchdog count=0, last_order=0.
  - Reset takes precedence over any same-cycle retire.
- FSM states:
  - IDLE: no retire seen yet. First rvfi_valid latches last_order=rvfi_order, performs the update, and moves to TRACK. No order check on the first retire.
  - TRACK: every valid retire is checked, then updated. Any error moves to FAIL.
  - FAIL: shadow and known keep updating; errors remain latched until reset.
- Order check (TRACK, valid): error when rvfi_order != last_order+1, with modulo 2^ORDER_W wrap, so all-ones followed by 0 is legal. On error, err_order=1 next cycle. last_order always takes rvfi_order.
- Trapped retires (valid && rvfi_trap):
  - Participate in the order check and reset the watchdog.
  - csr_rmask and csr_wmask are ignored; the shadow is unchanged.
- Data check (valid, !trap), on bits b where rmask[b] & known[b]:
  - Error when csr_rdata[b] != shadow[b]; err_data=1 next cycle.
  - Read bits that are not yet known are not checked; they become known through the read-learn rule below.
- Shadow update (valid, !trap), per bit:
  - wmask[b]=1: shadow[b]=wdata[b], known[b]=1.
  - Otherwise rmask[b]=1 and !known[b]: shadow[b]=rdata[b], known[b]=1 (read-learn).
  - Otherwise the bit is unchanged.
  - Write takes priority over read-learn in the same retire.
  - The data check uses the pre-update shadow, so a read-modify-write compares rdata against the old value.
- Watchdog (TRACK/FAIL, TIMEOUT>0):
  - Counter clears on any valid retire and increments otherwise, saturating at TIMEOUT.
  - When the counter reaches TIMEOUT, err_timeout=1 on that edge.
  - The counter is inactive in IDLE.
- Latency:
  - All outputs are registered.
  - Errors appear one cycle after the offending retire.
  - err_any appears one further cycle after the first err_* flag.
- Simultaneous errors: order and data errors from the same retire are both latched.

Optional Feature:
- Macro: RISCV_FORMAL_CSR_SHADOW_ASSERT_EN.
- Defined: immediate assert(!cond) at each error-detection point, i.e. the combinational condition in the offending cycle, gated by reset==1, for formal use. Output flags are unchanged.
- Undefined: no assert statements; flags only, for simulation and linting.

Decomposition:
- Shared package rvfi_csr_shadow_pkg holds:
  - FSM state enum (IDLE, TRACK, FAIL).
  - XLEN-independent constants: state encoding, TIMEOUT disable value 0.
- One natural sub-module: rvfi_retire_watchdog, containing the saturating counter and timeout flag, with inputs clock, reset, enable, kick, and output expired.

Test Plan:
- Retire order 0: wmask=FFFFFFFF, wdata=A5A5A5A5. Then retire order 1: rmask=FFFFFFFF, rdata=A5A5A5A5. Required: no error; shadow=A5A5A5A5, known=FFFFFFFF.
- Same sequence but the second retire has rdata=A5A5A5A4. Required: err_data=1 one cycle later, err_any=1 two cycles later, FSM=FAIL.
- Retire orders 5, 6, 8. Required: err_order=1 one cycle after order 8.
- Wrap case with ORDER_W=4: orders F then 0. Required: no error.
- TIMEOUT=4: one retire, then 4 idle cycles. Required: err_timeout=1 on the 4th idle edge. With a retire on idle cycle 3 instead: no error.
- Trapped retire with wmask=FFFFFFFF, wdata=0, followed by a read of FFFF0000 over a known FFFF0000 shadow. Required: no error and shadow unchanged. Then assert reset=0 mid-stream. Required: all outputs 0 and FSM=IDLE on the next edge.

Source files
------------

// File: rtl/rvfi_csr_shadow_pkg.sv
// ---------------------------------------------------------------------------
// rvfi_csr_shadow_pkg
// Shared definitions for the RVFI CSR shadow checker.
//   state_t      : checker FSM states (IDLE -> TRACK -> FAIL)
//   TIMEOUT_OFF  : TIMEOUT value that disables the retire watchdog
// ---------------------------------------------------------------------------
package rvfi_csr_shadow_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // no retire observed since reset
        ST_TRACK = 2'd1,   // retires observed, no error yet
        ST_FAIL  = 2'd2    // at least one error latched
    } state_t;

    localparam int TIMEOUT_OFF = 0;

endpackage

// File: rtl/rvfi_retire_watchdog.sv
// ---------------------------------------------------------------------------
// rvfi_retire_watchdog
// Saturating count of consecutive cycles without a retire.
//   clock   in  : clock
//   reset   in  : synchronous active-low reset
//   enable  in  : counter runs only while enabled
//   kick    in  : a retire this cycle, clears the count
//   expired out : sticky, set on the edge where the count reaches TIMEOUT
// TIMEOUT == TIMEOUT_OFF disables expiry.
// Optional: RISCV_FORMAL_CSR_SHADOW_ASSERT_EN adds an immediate assertion on
// the expiry condition.
// ---------------------------------------------------------------------------
module rvfi_retire_watchdog
    import rvfi_csr_shadow_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic kick,
    output logic expired
);

    // At least one bit so a disabled watchdog still has a legal counter.
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          hit;

    always_comb begin
        count_next = count;
        if (enable) begin
            if (kick) begin
                count_next = '0;
            end else if (count != LIMIT) begin
                count_next = count + 1'b1;
            end
        end
        hit = (TIMEOUT != TIMEOUT_OFF) && enable && !kick && (count_next == LIMIT);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count   <= '0;
            expired <= 1'b0;
        end else begin
            count <= count_next;
            if (hit) begin
                expired <= 1'b1;
            end
        end
    end

`ifdef RISCV_FORMAL_CSR_SHADOW_ASSERT_EN
    always_comb begin
        if (reset) begin
            assert (!hit);
        end
    end
`endif

endmodule

// File: rtl/rvfi_csr_shadow_check.sv
// ---------------------------------------------------------------------------
// rvfi_csr_shadow_check
// Tracks a shadow copy of one CSR from retired RVFI instructions and checks
// later readbacks against known shadow bits, retire order continuity and
// retire liveness.
//   clock, reset       : clock, synchronous active-low reset
//   rvfi_valid/order/trap : retirement strobe, index, trap flag
//   csr_rmask/wmask    : bits read / written by the retiring instruction
//   csr_rdata/wdata    : pre-write read value / post-write value
//   shadow, known      : shadow value and which of its bits are valid
//   err_data/order/timeout : sticky error flags, one cycle after the event
//   err_any            : registered OR of the three flags
//   fsm_state          : checker state, for observation
// Optional: RISCV_FORMAL_CSR_SHADOW_ASSERT_EN adds immediate assertions at
// the order and data error detection points (flags are unchanged).
//
// Handshake: rvfi_valid is a one-cycle qualifier; every other rvfi/csr input
// is sampled only on clock edges where rvfi_valid is 1. There is no ready.
// ---------------------------------------------------------------------------
module rvfi_csr_shadow_check
    import rvfi_csr_shadow_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ORDER_W = 64,
    parameter int TIMEOUT = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               rvfi_valid,
    input  logic [ORDER_W-1:0] rvfi_order,
    input  logic               rvfi_trap,
    input  logic [XLEN-1:0]    csr_rmask,
    input  logic [XLEN-1:0]    csr_wmask,
    input  logic [XLEN-1:0]    csr_rdata,
    input  logic [XLEN-1:0]    csr_wdata,
    output logic [XLEN-1:0]    shadow,
    output logic [XLEN-1:0]    known,
    output logic               err_data,
    output logic               err_order,
    output logic               err_timeout,
    output logic               err_any,
    output state_t             fsm_state
);

    state_t             state_next;
    logic [ORDER_W-1:0] last_order;
    logic [ORDER_W-1:0] order_exp;
    logic               chk_en;
    logic               order_bad;
    logic               data_bad;
    logic [XLEN-1:0]    learn;
    logic [XLEN-1:0]    shadow_next;
    logic [XLEN-1:0]    known_next;

    always_comb begin
        // Natural ORDER_W-bit wrap makes all-ones -> 0 legal.
        order_exp = last_order + 1'b1;
        // The first retire after reset has no predecessor to compare with.
        chk_en    = rvfi_valid && (fsm_state != ST_IDLE);
        order_bad = chk_en && (rvfi_order != order_exp);
        // Compare against the pre-update shadow so read-modify-write sees old data.
        data_bad  = chk_en && !rvfi_trap && (|(csr_rmask & known & (csr_rdata ^ shadow)));
        // Read-learn only fills unknown bits that this retire does not write.
        learn       = csr_rmask & ~known & ~csr_wmask;
        shadow_next = (csr_wdata & csr_wmask) | (csr_rdata & learn) |
                      (shadow & ~(csr_wmask | learn));
        known_next  = known | csr_wmask | csr_rmask;
    end

    always_comb begin
        state_next = fsm_state;
        case (fsm_state)
            ST_IDLE:  if (rvfi_valid) state_next = ST_TRACK;
            ST_TRACK: if (order_bad || data_bad || err_timeout) state_next = ST_FAIL;
            ST_FAIL:  state_next = ST_FAIL;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            fsm_state  <= ST_IDLE;
            last_order <= '0;
            shadow     <= '0;
            known      <= '0;
            err_data   <= 1'b0;
            err_order  <= 1'b0;
            err_any    <= 1'b0;
        end else begin
            fsm_state <= state_next;
            if (rvfi_valid) begin
                last_order <= rvfi_order;
                if (!rvfi_trap) begin
                    shadow <= shadow_next;
                    known  <= known_next;
                end
            end
            if (order_bad) err_order <= 1'b1;
            if (data_bad)  err_data  <= 1'b1;
            err_any <= err_data | err_order | err_timeout;
        end
    end

    rvfi_retire_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .enable  (fsm_state != ST_IDLE),
        .kick    (rvfi_valid),
        .expired (err_timeout)
    );

`ifdef RISCV_FORMAL_CSR_SHADOW_ASSERT_EN
    always_comb begin
        if (reset) begin
            assert (!order_bad);
            assert (!data_bad);
        end
    end
`endif

endmodule

// File: tb/tb_rvfi_csr_shadow_check.sv
// ---------------------------------------------------------------------------
// tb_rvfi_csr_shadow_check
// Directed scenarios followed by randomized retire streams, with a
// behavioural reference model of the shadow/order/watchdog rules.
// The DUT is built with ORDER_W=4 and TIMEOUT=4 so wrap and expiry are cheap.
// ---------------------------------------------------------------------------
module tb_rvfi_csr_shadow_check;
    import rvfi_csr_shadow_pkg::*;

    localparam int XLEN = 32;
    localparam int OW   = 4;
    localparam int TO   = 4;
    localparam int EW   = 2 * XLEN + 4 + 2;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic            reset;
    logic            rvfi_valid;
    logic [OW-1:0]   rvfi_order;
    logic            rvfi_trap;
    logic [XLEN-1:0] csr_rmask, csr_wmask, csr_rdata, csr_wdata;
    logic [XLEN-1:0] shadow, known;
    logic            err_data, err_order, err_timeout, err_any;
    state_t          fsm_state;

    rvfi_csr_shadow_check #(
        .XLEN    (XLEN),
        .ORDER_W (OW),
        .TIMEOUT (TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rvfi_valid  (rvfi_valid),
        .rvfi_order  (rvfi_order),
        .rvfi_trap   (rvfi_trap),
        .csr_rmask   (csr_rmask),
        .csr_wmask   (csr_wmask),
        .csr_rdata   (csr_rdata),
        .csr_wdata   (csr_wdata),
        .shadow      (shadow),
        .known       (known),
        .err_data    (err_data),
        .err_order   (err_order),
        .err_timeout (err_timeout),
        .err_any     (err_any),
        .fsm_state   (fsm_state)
    );

    // ---------------- scoreboard ----------------
    int    n_total = 0;
    int    n_bad   = 0;
    string phase   = "init";
    logic [EW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [XLEN-1:0] m_shadow, m_known;
    bit m_ed, m_eo, m_et, m_ea;
    bit m_started, m_fail;
    int m_last, m_idle;

    task automatic model_step(input bit rst_n, input bit v, input int ord, input bit trap,
                              input logic [XLEN-1:0] rm, input logic [XLEN-1:0] wm,
                              input logic [XLEN-1:0] rd, input logic [XLEN-1:0] wd);
        bit any_prev, et_prev, hit;
        state_t st;
        if (!rst_n) begin
            m_shadow = '0; m_known = '0;
            m_ed = 0; m_eo = 0; m_et = 0; m_ea = 0;
            m_started = 0; m_fail = 0; m_last = 0; m_idle = 0;
        end else begin
            any_prev = m_ed | m_eo | m_et;
            et_prev  = m_et;
            hit      = 0;
            if (v) begin
                if (m_started) begin
                    if (ord != (m_last + 1) % (1 << OW)) begin m_eo = 1; hit = 1; end
                    if (!trap)
                        for (int b = 0; b < XLEN; b++)
                            if (rm[b] && m_known[b] && rd[b] != m_shadow[b]) begin
                                m_ed = 1; hit = 1;
                            end
                    if (hit || et_prev) m_fail = 1;
                end
                if (!trap)
                    for (int b = 0; b < XLEN; b++) begin
                        if (wm[b]) begin
                            m_shadow[b] = wd[b]; m_known[b] = 1'b1;
                        end else if (rm[b] && !m_known[b]) begin
                            m_shadow[b] = rd[b]; m_known[b] = 1'b1;
                        end
                    end
                m_last = ord;
                m_idle = 0;
                m_started = 1;
            end else if (m_started) begin
                if (et_prev) m_fail = 1;
                if (m_idle < TO) m_idle++;
                if (m_idle == TO) m_et = 1;
            end
            m_ea = any_prev;
        end
        st = !m_started ? ST_IDLE : (m_fail ? ST_FAIL : ST_TRACK);
        exp_q.push_back({m_shadow, m_known, m_ed, m_eo, m_et, m_ea, st});
    endtask

    task automatic compare_outputs();
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            check({phase, "/queue_empty"}, 64'(exp_q.size()), 64'd1);
            return;
        end
        e = exp_q.pop_front();
        check({phase, "/shadow"},      64'(shadow),      64'(e[EW-1 -: XLEN]));
        check({phase, "/known"},       64'(known),       64'(e[EW-XLEN-1 -: XLEN]));
        check({phase, "/err_data"},    64'(err_data),    64'(e[5]));
        check({phase, "/err_order"},   64'(err_order),   64'(e[4]));
        check({phase, "/err_timeout"}, 64'(err_timeout), 64'(e[3]));
        check({phase, "/err_any"},     64'(err_any),     64'(e[2]));
        check({phase, "/state"},       64'(fsm_state),   64'(e[1:0]));
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc(input bit rst_n, input bit v, input int ord, input bit trap,
                       input logic [XLEN-1:0] rm, input logic [XLEN-1:0] wm,
                       input logic [XLEN-1:0] rd, input logic [XLEN-1:0] wd);
        reset      = rst_n;
        rvfi_valid = v;
        rvfi_order = OW'(ord);
        rvfi_trap  = trap;
        csr_rmask  = rm;
        csr_wmask  = wm;
        csr_rdata  = rd;
        csr_wdata  = wd;
        @(posedge clock);
        model_step(rst_n, v, ord, trap, rm, wm, rd, wd);
        #1;
        compare_outputs();
    endtask

    task automatic idle();
        cyc(1, 0, 0, 0, '0, '0, '0, '0);
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 0, '0, '0, '0, '0);
        cyc(0, 0, 0, 0, '0, '0, '0, '0);
    endtask

    task automatic retire(input int ord, input bit trap,
                          input logic [XLEN-1:0] rm, input logic [XLEN-1:0] wm,
                          input logic [XLEN-1:0] rd, input logic [XLEN-1:0] wd);
        cyc(1, 1, ord, trap, rm, wm, rd, wd);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [XLEN-1:0] rm, wm, rd, wd, pat;
        int ord;

        phase = "reset";
        do_reset();
        check("reset_state", 64'(fsm_state), 64'(ST_IDLE));

        phase = "rw_ok";
        retire(0, 0, '0, 32'hFFFF_FFFF, '0, 32'hA5A5_A5A5);
        retire(1, 0, 32'hFFFF_FFFF, '0, 32'hA5A5_A5A5, '0);
        check("rw_ok_shadow", 64'(shadow), 64'h0000_0000_A5A5_A5A5);
        check("rw_ok_known",  64'(known),  64'h0000_0000_FFFF_FFFF);
        check("rw_ok_err",    64'(err_data | err_order), 64'd0);

        phase = "rw_bad";
        do_reset();
        retire(0, 0, '0, 32'hFFFF_FFFF, '0, 32'hA5A5_A5A5);
        retire(1, 0, 32'hFFFF_FFFF, '0, 32'hA5A5_A5A4, '0);
        check("rw_bad_err_data", 64'(err_data), 64'd1);
        check("rw_bad_any_early", 64'(err_any), 64'd0);
        idle();
        check("rw_bad_err_any", 64'(err_any), 64'd1);
        check("rw_bad_state", 64'(fsm_state), 64'(ST_FAIL));

        phase = "order_gap";
        do_reset();
        retire(5, 0, '0, '0, '0, '0);
        retire(6, 0, '0, '0, '0, '0);
        check("order_ok", 64'(err_order), 64'd0);
        retire(8, 0, '0, '0, '0, '0);
        check("order_gap_err", 64'(err_order), 64'd1);

        phase = "order_wrap";
        do_reset();
        retire(15, 0, '0, '0, '0, '0);
        retire(0, 0, '0, '0, '0, '0);
        check("order_wrap_err", 64'(err_order), 64'd0);

        phase = "wdog_expire";
        do_reset();
        retire(0, 0, '0, '0, '0, '0);
        idle(); idle(); idle();
        check("wdog_3_idle", 64'(err_timeout), 64'd0);
        idle();
        check("wdog_4_idle", 64'(err_timeout), 64'd1);
        idle();

        phase = "wdog_kick";
        do_reset();
        retire(0, 0, '0, '0, '0, '0);
        idle(); idle();
        retire(1, 0, '0, '0, '0, '0);
        idle();
        check("wdog_kick_err", 64'(err_timeout), 64'd0);

        phase = "trap";
        do_reset();
        retire(0, 0, '0, 32'hFFFF_0000, '0, 32'hFFFF_0000);
        retire(1, 1, '0, 32'hFFFF_FFFF, '0, 32'h0000_0000);
        retire(2, 0, 32'hFFFF_0000, '0, 32'hFFFF_0000, '0);
        check("trap_shadow", 64'(shadow), 64'h0000_0000_FFFF_0000);
        check("trap_err", 64'(err_data | err_order | err_timeout), 64'd0);
        cyc(0, 1, 3, 0, '0, 32'hFFFF_FFFF, '0, 32'h1234_5678);
        check("midreset_shadow", 64'(shadow), 64'd0);
        check("midreset_state", 64'(fsm_state), 64'(ST_IDLE));

        phase = "random";
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                cyc(0, $urandom_range(0, 1), 0, 0, '0, '0, '0, '0);
            end else if ($urandom_range(0, 9) < 7) begin
                ord = (m_last + 1) % (1 << OW);
                if ($urandom_range(0, 15) == 0) ord = $urandom_range(0, (1 << OW) - 1);
                pat = {$urandom_range(0, 255) == 0 ? 32'h0 : 32'hFFFF_FFFF};
                rm  = $urandom & {8{4'($urandom_range(0, 15))}} & pat;
                wm  = $urandom & {8{4'($urandom_range(0, 15))}};
                wd  = $urandom;
                rd  = (m_shadow & m_known) | ($urandom & ~m_known);
                if ($urandom_range(0, 9) == 0) rd = rd ^ (32'd1 << $urandom_range(0, XLEN - 1));
                retire(ord, $urandom_range(0, 7) == 0, rm, wm, rd, wd);
            end else begin
                idle();
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
